multichannel_delta_rle_encoder: RTL and testbench
=================================================

# multichannel_delta_rle_encoder

Multi-channel delta + run-length encoder that turns interleaved per-channel sample streams into typed compressed packets. It sits between the channel sampler and the packet framer and supersedes the single-channel delta-only encoder. It adds real run-length coding of zero deltas, delta-overflow fallback to literal, per-channel state, an explicit flush, and backpressure-correct two-packet emission.

## Interface
Parameters:
- DATA_WIDTH, 16, sample and packet payload width
- NUM_CH, 4, number of interleaved channels (≥1)
- DELTA_WIDTH, 8, signed width a delta must fit to be sent as a delta packet (2..DATA_WIDTH)
- MAX_RUN, 255, saturating run length (1..2^DATA_WIDTH-1)
- CH_W (localparam), max(1,$clog2(NUM_CH))

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  sample, two's complement
- ch_in  in  CH_W  channel of data_in; values ≥NUM_CH are dropped (accepted, no state change, no packet)
- spike_in  in  1  sample flagged as spike
- valid_in  in  1  input valid
- ready_out  out  1  input ready
- flush_in  in  1  request to emit all pending runs
- flush_done  out  1  one-cycle pulse when flush completes
- pkt_data  out  DATA_WIDTH  packet payload
- pkt_type  out  2  00 delta, 01 run, 10 spike, 11 literal
- pkt_ch  out  CH_W  channel of packet
- valid_out  out  1  packet valid
- ready_in  in  1  downstream ready
- stat_samples, stat_packets, stat_spikes  out  32 each  statistics (see Configuration)

## Operation
- Per-channel state: prev[ch] (DATA_WIDTH), run[ch] (counter to MAX_RUN), first[ch] (set by reset).
- Accept = valid_in & ready_out. delta = data_in − prev[ch], computed at DATA_WIDTH+1 signed bits; "fits" means the value lies in [−2^(DELTA_WIDTH−1), 2^(DELTA_WIDTH−1)−1].
- Decision on accept, in priority order:
  - spike_in: packet type 10 with payload data_in.
  - first[ch]: packet type 11 with payload data_in; clear first[ch].
  - delta==0: run[ch]++, no packet. If run[ch] reaches MAX_RUN, emit run packet type 01 with payload MAX_RUN and clear run[ch].
  - delta fits: packet type 00 with payload delta sign-extended to DATA_WIDTH.
  - otherwise: packet type 11 with payload data_in.
- For the spike, delta-fits and literal cases: if run[ch]≠0, the run packet (type 01, payload run[ch]) is emitted first, the data packet second, and run[ch] is cleared.
- Every accepted sample on a valid channel sets prev[ch] ← data_in.
- FSM:
  - S_IDLE: accepts samples.
  - S_SECOND: a held second packet awaits the output slot. Moves to S_IDLE when that packet is loaded.
  - S_FLUSH: scans ch 0..NUM_CH−1 and loads a run packet for each nonzero run[ch] (clearing it) whenever the slot is free. After the last channel, waits until the slot is empty, pulses flush_done and returns to S_IDLE.
- flush_in is sampled only in S_IDLE and has priority over valid_in in the same cycle. Flush does not clear prev or first.

## Timing
- Output is a single registered slot. The slot loads when empty or when valid_out&ready_in in the same cycle (full throughput, no bubble).
- ready_out = (state==S_IDLE) & !flush_in & (slot empty | ready_in).
- Latency: accept in cycle N → valid_out in N+1. In the two-packet case, the run packet appears at N+1 and the data packet follows on the first cycle after the run packet is taken. ready_out stays low until then.
- While valid_out=1 & ready_in=0, pkt_* hold stable.
- Reset values: valid_out 0, pkt_data 0, pkt_type 00, pkt_ch 0, flush_done 0, ready_out follows its equation (1 after reset), stats 0.
- Per-channel state resets to prev 0, run 0, first 1.
- Reset asserted mid-operation discards the held packet, the slot contents and any in-progress flush.

## Configuration
- Macro DELTA_RLE_STATS_EN.
- Defined: stat_samples counts accepts, stat_packets counts packets handed off (valid_out&ready_in), stat_spikes counts accepted spikes. All three wrap modulo 2^32.
- Undefined: the counters are not built and all three stat outputs are tied to 0.

## Test plan
- Ch0 samples 100, 103, 99 with ready_in=1 → packets (11,100), (00,3), (00,−4 as 0xFFFC), each one cycle after its accept.
- Ch1 samples 50, 50, 50, 50, then 60 → (11,50), then (01,3) followed by (00,10); ready_out low for exactly one cycle.
- Ch0 samples 0, then 200 with DELTA_WIDTH=8 → (11,0), (11,200) (delta 200 does not fit).
- Interleaved ch0=5 and ch2=5, then 5 zero-delta samples on each channel, then flush_in → (11,5) ch0, (11,5) ch2, (01,5) ch0, (01,5) ch2, and flush_done pulses one cycle after the last packet is taken.
- MAX_RUN=3: ch3 samples 7, 7, 7, 7 → (11,7), (01,3); run resets and the next 7 produces no packet.
- ready_in held low for 10 cycles with 3 samples offered → only 1 accepted, pkt_* stable throughout. After ready_in rises, the stream continues with no loss or duplication. Define DELTA_RLE_STATS_EN and check stat_samples=3 and stat_packets=3 at the end.

Source files
------------

// File: rtl/multichannel_delta_rle_encoder_if.sv
// rtl/multichannel_delta_rle_encoder_if.sv - sample-in / packet-out / flush handshake bundle
interface multichannel_delta_rle_encoder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic [CH_W-1:0]       ch_in;
  logic                  spike_in;
  logic                  valid_in;
  logic                  ready_out;
  logic                  flush_in;
  logic                  flush_done;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic [1:0]            pkt_type;
  logic [CH_W-1:0]       pkt_ch;
  logic                  valid_out;
  logic                  ready_in;

  modport slave (
    input  data_in, ch_in, spike_in, valid_in, flush_in, ready_in,
    output ready_out, flush_done, pkt_data, pkt_type, pkt_ch, valid_out
  );

  modport master (
    output data_in, ch_in, spike_in, valid_in, flush_in, ready_in,
    input  ready_out, flush_done, pkt_data, pkt_type, pkt_ch, valid_out
  );
endinterface

// File: rtl/multichannel_delta_rle_encoder.sv
// rtl/multichannel_delta_rle_encoder.sv - per-channel delta + zero-run encoder with single output slot
// Optional statistics counters built when DELTA_RLE_STATS_EN is defined.
module multichannel_delta_rle_encoder #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 4,
  parameter int DELTA_WIDTH = 8,
  parameter int MAX_RUN     = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  multichannel_delta_rle_encoder_if.slave       bus,
  output logic [31:0]                           stat_samples,
  output logic [31:0]                           stat_packets,
  output logic [31:0]                           stat_spikes
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] MAX_RUN_V = RUN_W'(MAX_RUN);
  localparam logic [CH_W:0]    NUM_CH_V  = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] T_DELTA = 2'b00;
  localparam logic [1:0] T_RUN   = 2'b01;
  localparam logic [1:0] T_SPIKE = 2'b10;
  localparam logic [1:0] T_LIT   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SECOND, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [CH_W:0]         scan_q, scan_d;
  logic [DATA_WIDTH-1:0] prev_q [NUM_CH];
  logic [RUN_W-1:0]      run_q  [NUM_CH];
  logic [NUM_CH-1:0]     first_q;

  logic                  slot_vld_q;
  logic [DATA_WIDTH-1:0] slot_data_q;
  logic [1:0]            slot_type_q;
  logic [CH_W-1:0]       slot_ch_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic [1:0]            hold_type_q;
  logic [CH_W-1:0]       hold_ch_q;
  logic                  flush_done_q, flush_done_d;

  logic                  slot_free, rdy, accept, ch_ok, fits;
  logic [CH_W-1:0]       idx;
  logic [DATA_WIDTH-1:0] cur_prev;
  logic [RUN_W-1:0]      cur_run, run_inc;
  logic                  cur_first;
  logic [DATA_WIDTH:0]   delta;
  logic [DATA_WIDTH-DELTA_WIDTH+1:0] delta_hi;

  logic                  load, hold_we, prev_we, run_we, first_clr, emit;
  logic [DATA_WIDTH-1:0] ld_data, hd_data, em_data;
  logic [1:0]            ld_type, hd_type, em_type;
  logic [CH_W-1:0]       ld_ch;
  logic [RUN_W-1:0]      run_wd;

  assign slot_free = ~slot_vld_q | bus.ready_in;
  assign rdy       = (state_q == S_IDLE) & ~bus.flush_in & slot_free;
  assign accept    = bus.valid_in & rdy;
  assign ch_ok     = ({1'b0, bus.ch_in} < NUM_CH_V);

  // The single state port is shared by sample updates and the flush scan.
  assign idx       = (state_q == S_FLUSH) ? scan_q[CH_W-1:0] : bus.ch_in;
  assign cur_prev  = prev_q[idx];
  assign cur_run   = run_q[idx];
  assign cur_first = first_q[idx];
  assign run_inc   = cur_run + 1'b1;

  // Delta fits when every bit above the signed DELTA_WIDTH field matches the sign.
  assign delta     = {bus.data_in[DATA_WIDTH-1], bus.data_in} - {cur_prev[DATA_WIDTH-1], cur_prev};
  assign delta_hi  = delta[DATA_WIDTH:DELTA_WIDTH-1];
  assign fits      = (&delta_hi) | ~(|delta_hi);

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    flush_done_d = 1'b0;
    load         = 1'b0;
    ld_data      = '0;
    ld_type      = T_DELTA;
    ld_ch        = idx;
    hold_we      = 1'b0;
    hd_data      = '0;
    hd_type      = T_DELTA;
    prev_we      = 1'b0;
    run_we       = 1'b0;
    run_wd       = '0;
    first_clr    = 1'b0;
    emit         = 1'b0;
    em_data      = '0;
    em_type      = T_DELTA;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_in) begin
          state_d = S_FLUSH;
          scan_d  = '0;
        end else if (accept && ch_ok) begin
          prev_we = 1'b1;
          if (bus.spike_in) begin
            emit    = 1'b1;
            em_type = T_SPIKE;
            em_data = bus.data_in;
          end else if (cur_first) begin
            emit      = 1'b1;
            em_type   = T_LIT;
            em_data   = bus.data_in;
            first_clr = 1'b1;
          end else if (delta == '0) begin
            run_we = 1'b1;
            if (run_inc == MAX_RUN_V) begin
              load    = 1'b1;
              ld_type = T_RUN;
              ld_data = DATA_WIDTH'(MAX_RUN_V);
              run_wd  = '0;
            end else begin
              run_wd = run_inc;
            end
          end else if (fits) begin
            emit    = 1'b1;
            em_type = T_DELTA;
            em_data = delta[DATA_WIDTH-1:0];
          end else begin
            emit    = 1'b1;
            em_type = T_LIT;
            em_data = bus.data_in;
          end
          // A pending run goes out ahead of the data packet, which is parked.
          if (emit) begin
            load = 1'b1;
            if (cur_run != '0) begin
              ld_type = T_RUN;
              ld_data = DATA_WIDTH'(cur_run);
              run_we  = 1'b1;
              run_wd  = '0;
              hold_we = 1'b1;
              hd_data = em_data;
              hd_type = em_type;
              state_d = S_SECOND;
            end else begin
              ld_type = em_type;
              ld_data = em_data;
            end
          end
        end
      end
      S_SECOND: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_type = hold_type_q;
          ld_data = hold_data_q;
          ld_ch   = hold_ch_q;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (scan_q < NUM_CH_V) begin
          if (cur_run == '0) begin
            scan_d = scan_q + 1'b1;
          end else if (slot_free) begin
            load    = 1'b1;
            ld_type = T_RUN;
            ld_data = DATA_WIDTH'(cur_run);
            run_we  = 1'b1;
            run_wd  = '0;
            scan_d  = scan_q + 1'b1;
          end
        end else if (slot_free) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scan_q       <= '0;
      slot_vld_q   <= 1'b0;
      slot_data_q  <= '0;
      slot_type_q  <= T_DELTA;
      slot_ch_q    <= '0;
      hold_data_q  <= '0;
      hold_type_q  <= T_DELTA;
      hold_ch_q    <= '0;
      flush_done_q <= 1'b0;
      first_q      <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        run_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      flush_done_q <= flush_done_d;
      if (load) begin
        slot_vld_q  <= 1'b1;
        slot_data_q <= ld_data;
        slot_type_q <= ld_type;
        slot_ch_q   <= ld_ch;
      end else if (bus.ready_in) begin
        slot_vld_q <= 1'b0;
      end
      if (hold_we) begin
        hold_data_q <= hd_data;
        hold_type_q <= hd_type;
        hold_ch_q   <= bus.ch_in;
      end
      if (prev_we)   prev_q[idx]  <= bus.data_in;
      if (run_we)    run_q[idx]   <= run_wd;
      if (first_clr) first_q[idx] <= 1'b0;
    end
  end

  assign bus.ready_out  = rdy;
  assign bus.valid_out  = slot_vld_q;
  assign bus.pkt_data   = slot_data_q;
  assign bus.pkt_type   = slot_type_q;
  assign bus.pkt_ch     = slot_ch_q;
  assign bus.flush_done = flush_done_q;

`ifdef DELTA_RLE_STATS_EN
  logic [31:0] samples_q, packets_q, spikes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q <= '0;
      packets_q <= '0;
      spikes_q  <= '0;
    end else begin
      samples_q <= samples_q + 32'(accept);
      packets_q <= packets_q + 32'(slot_vld_q & bus.ready_in);
      spikes_q  <= spikes_q + 32'(accept & bus.spike_in);
    end
  end

  assign stat_samples = samples_q;
  assign stat_packets = packets_q;
  assign stat_spikes  = spikes_q;
`else
  assign stat_samples = 32'd0;
  assign stat_packets = 32'd0;
  assign stat_spikes  = 32'd0;
`endif
endmodule

// File: tb/tb_multichannel_delta_rle_encoder.sv
// tb/tb_multichannel_delta_rle_encoder.sv - directed bench for multichannel_delta_rle_encoder
module tb_multichannel_delta_rle_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multichannel_delta_rle_encoder_if #(.DATA_WIDTH(16), .NUM_CH(4)) bus ();
  multichannel_delta_rle_encoder_if #(.DATA_WIDTH(16), .NUM_CH(4)) bus3 ();

  logic [31:0] s_smp, s_pkt, s_spk, s3_smp, s3_pkt, s3_spk;

  assign bus3.data_in  = bus.data_in;
  assign bus3.ch_in    = bus.ch_in;
  assign bus3.spike_in = bus.spike_in;
  assign bus3.valid_in = bus.valid_in;
  assign bus3.flush_in = bus.flush_in;
  assign bus3.ready_in = bus.ready_in;

  multichannel_delta_rle_encoder #(
    .DATA_WIDTH(16), .NUM_CH(4), .DELTA_WIDTH(8), .MAX_RUN(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_samples(s_smp), .stat_packets(s_pkt), .stat_spikes(s_spk)
  );

  multichannel_delta_rle_encoder #(
    .DATA_WIDTH(16), .NUM_CH(4), .DELTA_WIDTH(8), .MAX_RUN(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .stat_samples(s3_smp), .stat_packets(s3_pkt), .stat_spikes(s3_spk)
  );

  int checks = 0;
  int errors = 0;
  int npk;
  logic got_done;
  logic [31:0] pk [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input string tag, input logic [1:0] t, input logic [15:0] d, input logic [1:0] c);
    chk({tag, "_vld"},  32'(bus.valid_out), 32'd1);
    chk({tag, "_type"}, 32'(bus.pkt_type),  32'(t));
    chk({tag, "_data"}, 32'(bus.pkt_data),  32'(d));
    chk({tag, "_ch"},   32'(bus.pkt_ch),    32'(c));
  endtask

  task automatic expect_pkt3(input string tag, input logic [1:0] t, input logic [15:0] d, input logic [1:0] c);
    chk({tag, "_vld"},  32'(bus3.valid_out), 32'd1);
    chk({tag, "_type"}, 32'(bus3.pkt_type),  32'(t));
    chk({tag, "_data"}, 32'(bus3.pkt_data),  32'(d));
    chk({tag, "_ch"},   32'(bus3.pkt_ch),    32'(c));
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    chk("rst_vld",   32'(bus.valid_out),  32'd0);
    chk("rst_data",  32'(bus.pkt_data),   32'd0);
    chk("rst_type",  32'(bus.pkt_type),   32'd0);
    chk("rst_ch",    32'(bus.pkt_ch),     32'd0);
    chk("rst_done",  32'(bus.flush_done), 32'd0);
    chk("rst_rdy",   32'(bus.ready_out),  32'd1);
    chk("rst_smp",   s_smp, 32'd0);
    chk("rst_pkt",   s_pkt, 32'd0);
    chk("rst_vld3",  32'(bus3.valid_out), 32'd0);
    tick;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] d, input logic sp);
    int n;
    n = 0;
    bus.ch_in    = c;
    bus.data_in  = d;
    bus.spike_in = sp;
    bus.valid_in = 1'b1;
    while (bus.ready_out !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("send_ready", 32'(bus.ready_out), 32'd1);
    tick;
    bus.valid_in = 1'b0;
    bus.spike_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.data_in  = '0;
    bus.ch_in    = '0;
    bus.spike_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.flush_in = 1'b0;
    bus.ready_in = 1'b1;
    #2;
    do_reset;

    // Literal then two deltas on ch0
    send(2'd0, 16'd100, 1'b0);
    expect_pkt("c0_lit", 2'b11, 16'd100, 2'd0);
    send(2'd0, 16'd103, 1'b0);
    expect_pkt("c0_d3", 2'b00, 16'd3, 2'd0);
    send(2'd0, 16'd99, 1'b0);
    expect_pkt("c0_dm4", 2'b00, 16'hFFFC, 2'd0);
    tick;
    chk("c0_drain", 32'(bus.valid_out), 32'd0);

    // Run of three zero deltas on ch1 then a delta: two-packet emission
    send(2'd1, 16'd50, 1'b0);
    expect_pkt("c1_lit", 2'b11, 16'd50, 2'd1);
    for (int i = 0; i < 3; i++) begin
      send(2'd1, 16'd50, 1'b0);
      chk("c1_run_nopkt", 32'(bus.valid_out), 32'd0);
    end
    send(2'd1, 16'd60, 1'b0);
    expect_pkt("c1_run", 2'b01, 16'd3, 2'd1);
    chk("c1_rdy_low", 32'(bus.ready_out), 32'd0);
    tick;
    expect_pkt("c1_d10", 2'b00, 16'd10, 2'd1);
    chk("c1_rdy_back", 32'(bus.ready_out), 32'd1);
    tick;
    chk("c1_drain", 32'(bus.valid_out), 32'd0);

    // Oversized delta falls back to literal; spike wins over delta
    send(2'd3, 16'd0, 1'b0);
    expect_pkt("c3_lit0", 2'b11, 16'd0, 2'd3);
    send(2'd3, 16'd200, 1'b0);
    expect_pkt("c3_lit200", 2'b11, 16'd200, 2'd3);
    send(2'd3, 16'd205, 1'b1);
    expect_pkt("c3_spike", 2'b10, 16'd205, 2'd3);
    do_reset;

    // Interleaved runs on ch0 and ch2, then flush
    send(2'd0, 16'd5, 1'b0);
    expect_pkt("fl_lit0", 2'b11, 16'd5, 2'd0);
    send(2'd2, 16'd5, 1'b0);
    expect_pkt("fl_lit2", 2'b11, 16'd5, 2'd2);
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 16'd5, 1'b0);
      send(2'd2, 16'd5, 1'b0);
    end
    chk("fl_nopkt", 32'(bus.valid_out), 32'd0);
    bus.flush_in = 1'b1;
    #1;
    chk("fl_rdy_low", 32'(bus.ready_out), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    npk = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (bus.valid_out === 1'b1) begin
        if (npk < 4) pk[npk] = {12'd0, bus.pkt_type, bus.pkt_ch, bus.pkt_data};
        npk++;
      end
      if (bus.flush_done === 1'b1) begin
        got_done = 1'b1;
        chk("fl_done_slot_empty", 32'(bus.valid_out), 32'd0);
      end else begin
        chk("fl_busy_rdy", 32'(bus.ready_out), 32'd0);
        tick;
      end
    end
    chk("fl_done_seen", 32'(got_done), 32'd1);
    chk("fl_npk", 32'(npk), 32'd2);
    chk("fl_pk0", pk[0], {12'd0, 2'b01, 2'd0, 16'd5});
    chk("fl_pk1", pk[1], {12'd0, 2'b01, 2'd2, 16'd5});
    tick;
    chk("fl_done_pulse", 32'(bus.flush_done), 32'd0);
    chk("fl_rdy_idle", 32'(bus.ready_out), 32'd1);

    // Run saturation: dut3 has MAX_RUN=3, dut has 255
    do_reset;
    send(2'd3, 16'd7, 1'b0);
    expect_pkt("sat_lit", 2'b11, 16'd7, 2'd3);
    expect_pkt3("sat3_lit", 2'b11, 16'd7, 2'd3);
    for (int i = 0; i < 2; i++) begin
      send(2'd3, 16'd7, 1'b0);
      chk("sat3_nopkt", 32'(bus3.valid_out), 32'd0);
    end
    send(2'd3, 16'd7, 1'b0);
    expect_pkt3("sat3_run", 2'b01, 16'd3, 2'd3);
    chk("sat_main_nopkt", 32'(bus.valid_out), 32'd0);
    send(2'd3, 16'd7, 1'b0);
    chk("sat3_after", 32'(bus3.valid_out), 32'd0);
    chk("sat_main_after", 32'(bus.valid_out), 32'd0);
    send(2'd3, 16'd8, 1'b0);
    expect_pkt("sat_run4", 2'b01, 16'd4, 2'd3);
    expect_pkt3("sat3_run1", 2'b01, 16'd1, 2'd3);
    chk("sat3_rdy_low", 32'(bus3.ready_out), 32'd0);
    tick;
    expect_pkt("sat_d1", 2'b00, 16'd1, 2'd3);
    expect_pkt3("sat3_d1", 2'b00, 16'd1, 2'd3);

    // Backpressure: slot held stable, no loss or duplication after release
    do_reset;
    bus.ready_in = 1'b0;
    send(2'd0, 16'd10, 1'b0);
    expect_pkt("bp_first", 2'b11, 16'd10, 2'd0);
    bus.ch_in    = 2'd0;
    bus.data_in  = 16'd12;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rdy_low", 32'(bus.ready_out), 32'd0);
      chk("bp_hold_vld", 32'(bus.valid_out), 32'd1);
      chk("bp_hold_type", 32'(bus.pkt_type), 32'd3);
      chk("bp_hold_data", 32'(bus.pkt_data), 32'd10);
      tick;
    end
    bus.ready_in = 1'b1;
    #1;
    chk("bp_rdy_rise", 32'(bus.ready_out), 32'd1);
    @(posedge clk);
    #1;
    expect_pkt("bp_d2", 2'b00, 16'd2, 2'd0);
    bus.data_in = 16'd15;
    tick;
    bus.valid_in = 1'b0;
    expect_pkt("bp_d3", 2'b00, 16'd3, 2'd0);
    tick;
    chk("bp_drain", 32'(bus.valid_out), 32'd0);
`ifdef DELTA_RLE_STATS_EN
    chk("stat_samples", s_smp, 32'd3);
    chk("stat_packets", s_pkt, 32'd3);
    chk("stat_spikes",  s_spk, 32'd0);
`else
    chk("stat_samples_off", s_smp, 32'd0);
    chk("stat_packets_off", s_pkt, 32'd0);
    chk("stat_spikes_off",  s_spk, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
